// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer/UART-side bundle for uart_tx_arbiter.
//   req       : per-requester request level, held until the matching ack
//   req_data  : one byte per requester (lane i = requester i)
//   ack       : one-cycle accept pulse, one-hot
//   tx_data   : byte presented to the UART TX engine
//   tx_start  : one-cycle launch pulse to the UART TX engine
//   tx_busy   : UART TX engine busy flag
// Modports:
//   slave  - the arbiter
//   master - the environment (producers plus the UART engine)
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_REQ-1:0]             ack;
  logic [DATA_W-1:0]            tx_data;
  logic                         tx_start;
  logic                         tx_busy;

  modport slave  (input  req, req_data, tx_busy,
                  output ack, tx_data, tx_start);
  modport master (output req, req_data, tx_busy,
                  input  ack, tx_data, tx_start);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// N_REQ byte producers. One byte per grant, launched with a one-cycle
// tx_start, then tx_busy is tracked until the byte finishes. A watchdog
// on the busy rise keeps a dead transmitter from locking the arbiter.
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   bus           : producer/UART bundle (slave modport)
//   grant_id_o    : index of the last granted requester
//   active_o      : high whenever the FSM is not in IDLE
//   timeout_err_o : one-cycle pulse when the busy watchdog expires
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_arbiter_if.slave         bus,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     active_o,
  output logic                     timeout_err_o
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic [N_REQ-1:0]  ack_q;
  logic              timeout_err_q;
  logic [7:0]        tout_cnt_q;

  // Round-robin search starting at ptr+1. Walking offsets from the far end
  // down to 1 and overwriting leaves the nearest set request as the winner.
  logic            win_vld;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] idx;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = ID_W'((int'(ptr_q) + off) % N_REQ);
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(N_REQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
      tout_cnt_q    <= '0;
    end else begin
      // Pulses default low; only a grant or an expiry raises them.
      tx_start_q    <= 1'b0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A busy transmitter here is external use or a byte still in
          // flight across a reset: hold off until it goes quiet.
          if (win_vld && !bus.tx_busy) begin
            tx_data_q  <= bus.req_data[win_id];
            tx_start_q <= 1'b1;
            ack_q      <= N_REQ'(1) << win_id;
            grant_id_q <= win_id;
            ptr_q      <= win_id;
            tout_cnt_q <= '0;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // tout_cnt_q reads k-1 on the k-th WAIT_BUSY edge, so expiry lands
          // BUSY_TIMEOUT+1 cycles after the tx_start cycle. ptr_q is kept.
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tout_cnt_q == 8'(BUSY_TIMEOUT)) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            tout_cnt_q <= tout_cnt_q + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.ack        = ack_q;
  assign grant_id_o     = grant_id_q;
  assign active_o       = (state_q != IDLE);
  assign timeout_err_o  = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a small UART
// model (busy for BUSY_LEN cycles starting the cycle tx_start is seen) and
// optional producer behaviour that drops req on its ack.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();
  logic [1:0] gid;
  logic       act;
  logic       terr;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .BUSY_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .grant_id_o    (gid),
    .active_o      (act),
    .timeout_err_o (terr)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit         uart_en;
  bit         drop;
  int         busy_cnt;
  int         n;
  int         overlap;
  logic [1:0] gid_log [16];
  logic [7:0] byte_log[16];

  // One clock: sample #1 after the edge, log launches, run the UART and
  // producer models, then leave new inputs for the next edge.
  task automatic step();
    @(posedge clk); #1;
    if (bus.tx_start) begin
      if (bus.tx_busy) overlap++;
      if (n < 16) begin
        gid_log[n]  = gid;
        byte_log[n] = bus.tx_data;
      end
      n++;
    end
    if (uart_en) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
      end
      if (bus.tx_start) begin
        bus.tx_busy = 1'b1;
        busy_cnt    = BUSY_LEN;
      end
    end
    if (drop) bus.req = bus.req & ~bus.ack;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    busy_cnt     = 0;
    n            = 0;
    uart_en      = 1'b1;
    drop         = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int d;
    int starts;
    int n0;
    overlap = 0;

    // Reset values
    do_reset();
    chk("rst_start", 32'(bus.tx_start), 0);
    chk("rst_ack",   32'(bus.ack), 0);
    chk("rst_data",  32'(bus.tx_data), 0);
    chk("rst_gid",   32'(gid), 0);
    chk("rst_act",   32'(act), 0);
    chk("rst_terr",  32'(terr), 0);

    // 1: single request
    do_reset();
    bus.req_data[2] = 8'h41;
    bus.req         = 4'b0100;
    step();
    chk("t1_start", 32'(bus.tx_start), 1);
    chk("t1_ack",   32'(bus.ack), 32'h4);
    chk("t1_data",  32'(bus.tx_data), 32'h41);
    chk("t1_gid",   32'(gid), 2);
    chk("t1_act",   32'(act), 1);
    for (int i = 0; i < 40 && bus.tx_busy; i++) step();
    chk("t1_busy_fell", 32'(bus.tx_busy), 0);
    chk("t1_act_hold",  32'(act), 1);
    step();
    chk("t1_idle", 32'(act), 0);

    // 2: simultaneous requests
    do_reset();
    for (int i = 0; i < N; i++) bus.req_data[i] = 8'(8'h10 + i);
    bus.req = 4'hF;
    for (int i = 0; i < 200 && n < 4; i++) step();
    chk("t2_count", 32'(n), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_gid%0d", k),  32'(gid_log[k]), 32'(k));
      chk($sformatf("t2_byte%0d", k), 32'(byte_log[k]), 32'(8'h10 + k));
    end
    chk("t2_overlap", 32'(overlap), 0);

    // 3: fairness with req[0] and req[2] held
    do_reset();
    drop    = 1'b0;
    bus.req = 4'b0101;
    for (int i = 0; i < 400 && n < 6; i++) step();
    chk("t3_count", 32'(n), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_gid%0d", k), 32'(gid_log[k]), (k % 2 == 0) ? 32'd0 : 32'd2);

    // 4: watchdog with tx_busy tied low
    do_reset();
    uart_en = 1'b0;
    bus.req = 4'b0010;
    step();
    chk("t4_start", 32'(bus.tx_start), 1);
    d = 0;
    for (int i = 0; i < 100 && !terr; i++) begin
      step();
      d++;
    end
    chk("t4_delay", 32'(d), 32'(TO + 1));
    chk("t4_idle",  32'(act), 0);
    step();
    chk("t4_pulse", 32'(terr), 0);
    bus.req = 4'b0101;
    step();
    chk("t4_start2", 32'(bus.tx_start), 1);
    chk("t4_next",   32'(gid), 2);

    // 5: transmitter busy when the request arrives
    do_reset();
    uart_en     = 1'b0;
    bus.tx_busy = 1'b1;
    bus.req     = 4'b0010;
    starts      = 0;
    repeat (4) begin
      step();
      if (bus.tx_start) starts++;
    end
    chk("t5_nostart", 32'(starts), 0);
    bus.tx_busy = 1'b0;
    step();
    chk("t5_start", 32'(bus.tx_start), 1);
    chk("t5_gid",   32'(gid), 1);

    // 6: reset while in WAIT_DONE
    do_reset();
    bus.req_data[1] = 8'h5A;
    bus.req         = 4'b0010;
    step();
    step();
    chk("t6_pre_act", 32'(act), 1);
    chk("t6_pre_gid", 32'(gid), 1);
    rst_n = 1'b0;
    #2;
    chk("t6_act",   32'(act), 0);
    chk("t6_gid",   32'(gid), 0);
    chk("t6_data",  32'(bus.tx_data), 0);
    chk("t6_start", 32'(bus.tx_start), 0);
    chk("t6_ack",   32'(bus.ack), 0);
    chk("t6_terr",  32'(terr), 0);
    step();
    rst_n   = 1'b1;
    bus.req = 4'b0101;
    n0      = n;
    for (int i = 0; i < 60 && n == n0; i++) step();
    chk("t6_grant", 32'(n - n0), 1);
    chk("t6_gid0",  32'(gid_log[n0]), 0);
    chk("all_overlap", 32'(overlap), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
